day_counter: RTL
================

Name: day_counter

Overview:
- Day-of-month counter in the calendar chain of the millennium clock.
- Counts on the rollover carry from the hour stage.
- Produces the day value and a one-cycle carry that drives the month stage's carry_in.
- Month length comes from the current month and year, including Gregorian leap years; the day can also be set manually with up/down.

Parameters:
- SELECT_DAY, 3'b011, select_item code that places this block in manual-adjust mode.
- YEAR_W, 12, width of the binary full-year input (0..4095).

Ports:
- clk_1Hz  input  1  system tick clock.
- rst_n  input  1  asynchronous active-low reset.
- en_1  input  1  counting enable (clock running, not in setup).
- up  input  1  manual increment request, sampled each edge while selected.
- down  input  1  manual decrement request; ignored when up is high.
- select_item  input  3  item under adjustment.
- carry_in  input  1  day-advance pulse from the hour stage (23->0 rollover).
- month_bin  input  4  current month, 1..12, from the month stage.
- year_bin  input  YEAR_W  current full year, binary, from the year stage.
- day_bin  output  5  current day, 1..31, registered.
- max_day  output  5  days in current month (28/29/30/31), combinational from month_bin/year_bin.
- carry_out  output  1  registered one-cycle pulse to the month stage on month-end rollover.

Behaviour:
- Reset: asynchronous on rst_n low. day_bin=1 and carry_out=0, held until rst_n is high. Reset mid-rollover discards any pending carry.
- Leap year: (year%4==0 && year%100!=0) || year%400==0. Examples: 2000 and 2024 are leap; 2100 and 2023 are not.
- max_day:
  - Months 4, 6, 9, 11 give 30.
  - Month 2 gives 29 if leap, else 28.
  - All other valid months give 31.
  - Out-of-range month_bin (0, 13..15) gives 31.
- Priority per clk_1Hz edge, highest first:
  1. Adjust, when select_item==SELECT_DAY:
     - up: day_bin>=max_day wraps to 1, else +1.
     - down: day_bin<=1 goes to max_day, else -1.
     - Neither: hold.
     - carry_out=0 always; manual edits never carry.
  2. Count, when en_1 && carry_in:
     - day_bin>=max_day: day_bin<=1 and carry_out<=1.
     - Otherwise day_bin+1 and carry_out<=0.
  3. Clamp, when day_bin>max_day (month/year was edited under a long day): day_bin<=max_day, carry_out<=0.
  4. Otherwise: hold day_bin, carry_out<=0.
- carry_out is high for exactly one clk_1Hz cycle following the rollover edge. The month stage samples it on the next edge; total day-to-month latency is 1 cycle.
- Back-to-back carry_in pulses are each counted. No pulse is merged or lost.
- Simultaneous up and down: up wins.
- Simultaneous adjust and carry_in: adjust wins; the carry_in pulse is dropped, consistent with the month stage.
- The ">=" comparisons make an out-of-range day self-correcting in both adjust and count modes.
- day_bin is never 0 and never exceeds 31 after any edge.

Decomposition:
- Shared package cal_pkg:
  - select_item codes (SELECT_DAY, SELECT_MONTH, ...).
  - month constants (FEB=2, APR=4, JUN=6, SEP=9, NOV=11).
  - DAY_W=5, MONTH_W=4.
- One natural sub-module: days_in_month. Purely combinational; inputs month_bin and year_bin, output max_day. It contains the leap-year logic and is reused by the setup/display path.

Test Plan:
- Reset: rst_n low mid-count with day=17 -> day_bin=1, carry_out=0 immediately (asynchronous); first carry_in after release -> day_bin=2.
- Month-end rollover: month=1, year=2023, day=31, en_1=1, carry_in pulse -> day_bin=1, carry_out=1 for one cycle only; next edge carry_out=0. Same test with month=4, day=30 -> rollover to 1.
- February/leap: year=2023, month=2, day=28, carry_in -> 1 with carry. year=2024, day=28 -> 29, no carry, then next carry_in -> 1 with carry. year=2100, day=28 -> 1 with carry. year=2000, day=28 -> 29.
- Manual adjust: select_item=SELECT_DAY, month=4, day=1, down -> 30; up at 30 -> 1; up and down together at day=5 -> 6; carry_in asserted during adjust -> no count, carry_out stays 0.
- Clamp: day=31, month changed 1->4 with select_item idle -> next edge day_bin=30, carry_out=0. day=30, month changed to 2 with year=2023 -> day_bin=28.
- Stress: 400 consecutive carry_in pulses starting 2024-01-01, with month advanced by the bench on each carry_out -> carry_out count and day_bin at each month boundary match the reference calendar.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared calendar-chain definitions: adjust-item codes, month numbers and field widths.
package cal_pkg;

   localparam int unsigned DAY_W   = 5;
   localparam int unsigned MONTH_W = 4;

   localparam logic [2:0] SELECT_IDLE  = 3'b000;
   localparam logic [2:0] SELECT_MIN   = 3'b001;
   localparam logic [2:0] SELECT_HOUR  = 3'b010;
   localparam logic [2:0] SELECT_DAY   = 3'b011;
   localparam logic [2:0] SELECT_MONTH = 3'b100;
   localparam logic [2:0] SELECT_YEAR  = 3'b101;

   localparam logic [MONTH_W-1:0] FEB = 4'd2;
   localparam logic [MONTH_W-1:0] APR = 4'd4;
   localparam logic [MONTH_W-1:0] JUN = 4'd6;
   localparam logic [MONTH_W-1:0] SEP = 4'd9;
   localparam logic [MONTH_W-1:0] NOV = 4'd11;

endpackage

// File: rtl/days_in_month.sv
// Combinational month length with Gregorian leap-year rule; shared with the setup/display path.
module days_in_month
   import cal_pkg::*;
#(
   parameter int unsigned YEAR_W = 12
) (
   input  logic [MONTH_W-1:0] month_bin,
   input  logic [YEAR_W-1:0]  year_bin,
   output logic [DAY_W-1:0]   max_day
);

   logic w_leap;

   assign w_leap = ((year_bin[1:0] == 2'b00) && ((year_bin % YEAR_W'(100)) != '0))
                || ((year_bin % YEAR_W'(400)) == '0);

   always_comb begin
      max_day = 5'd31;
      unique case (month_bin)
         FEB:                max_day = w_leap ? 5'd29 : 5'd28;
         APR, JUN, SEP, NOV: max_day = 5'd30;
         default:            max_day = 5'd31;
      endcase
   end

endmodule

// File: rtl/day_counter.sv
// Day-of-month stage: counts hour-stage rollovers, carries into the month stage, manual up/down.
module day_counter
   import cal_pkg::*;
#(
   parameter logic [2:0]  SELECT_DAY = cal_pkg::SELECT_DAY,
   parameter int unsigned YEAR_W     = 12
) (
   input  logic               clk_1Hz,
   input  logic               rst_n,
   input  logic               en_1,
   input  logic               up,
   input  logic               down,
   input  logic [2:0]         select_item,
   input  logic               carry_in,
   input  logic [MONTH_W-1:0] month_bin,
   input  logic [YEAR_W-1:0]  year_bin,
   output logic [DAY_W-1:0]   day_bin,
   output logic [DAY_W-1:0]   max_day,
   output logic               carry_out
);

   logic [DAY_W-1:0] r_day;
   logic             r_carry;
   logic [DAY_W-1:0] w_max_day;

   days_in_month #(
      .YEAR_W (YEAR_W)
   ) u_days_in_month (
      .month_bin (month_bin),
      .year_bin  (year_bin),
      .max_day   (w_max_day)
   );

   // Adjust beats count beats clamp; ">=" / "<=" keep an out-of-range day self-correcting.
   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         r_day   <= 5'd1;
         r_carry <= 1'b0;
      end else begin
         r_carry <= 1'b0;
         if (select_item == SELECT_DAY) begin
            if (up) begin
               r_day <= (r_day >= w_max_day) ? 5'd1 : r_day + 5'd1;
            end else if (down) begin
               r_day <= (r_day <= 5'd1) ? w_max_day : r_day - 5'd1;
            end
         end else if (en_1 && carry_in) begin
            if (r_day >= w_max_day) begin
               r_day   <= 5'd1;
               r_carry <= 1'b1;
            end else begin
               r_day <= r_day + 5'd1;
            end
         end else if (r_day > w_max_day) begin
            r_day <= w_max_day;
         end
      end
   end

   assign day_bin   = r_day;
   assign carry_out = r_carry;
   assign max_day   = w_max_day;

endmodule
